// File: rtl/cache_replacement_pkg.sv
// Shared definitions for the cache replacement engines.
//   counter_width() : width of line indices / age counters for a given line count
//   lru_age()       : age value that marks the least recently used line
//   age_op_e        : kind of operation applied to the age vector
package cache_replacement_pkg;

    typedef enum logic {
        OpAccess,
        OpInvalidate
    } age_op_e;

    // At least one bit, even for a two-line set.
    function automatic int unsigned counter_width(input int unsigned lines);
        if (lines <= 2) begin
            return 1;
        end
        return $clog2(lines);
    endfunction

    function automatic int unsigned lru_age(input int unsigned lines);
        return lines - 1;
    endfunction

endpackage

// File: rtl/lru_age_update.sv
// Combinational next-state for the true-LRU age vector under one operation.
//   ages      : current age of every line (0 = MRU, N-1 = LRU)
//   op        : OpAccess moves the line to MRU, OpInvalidate moves it to LRU
//   index     : line the operation targets; out-of-range indices are ignored
//   enable    : operation is present this cycle
//   ages_next : resulting age vector (equals ages when nothing applies)
module lru_age_update
    import cache_replacement_pkg::*;
#(
    parameter int unsigned NUMBER_OF_CACHE_LINES = 4,
    parameter int unsigned COUNTER_WIDTH = counter_width(NUMBER_OF_CACHE_LINES)
) (
    input  logic [NUMBER_OF_CACHE_LINES-1:0][COUNTER_WIDTH-1:0] ages,
    input  age_op_e                                           op,
    input  logic [COUNTER_WIDTH-1:0]                          index,
    input  logic                                              enable,
    output logic [NUMBER_OF_CACHE_LINES-1:0][COUNTER_WIDTH-1:0] ages_next
);

    localparam int unsigned N = NUMBER_OF_CACHE_LINES;
    localparam logic [COUNTER_WIDTH-1:0] LruAge = COUNTER_WIDTH'(lru_age(N));

    logic                     in_range;
    logic [COUNTER_WIDTH-1:0] cur_age;

    always_comb begin
        in_range = (32'(index) < N);
        cur_age  = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (index == COUNTER_WIDTH'(j)) begin
                cur_age = ages[j];
            end
        end
    end

    // Increments only touch ages below cur_age and decrements only ages above it,
    // so no counter can wrap.
    always_comb begin
        ages_next = ages;
        if (enable && in_range) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (index == COUNTER_WIDTH'(j)) begin
                    ages_next[j] = (op == OpAccess) ? '0 : LruAge;
                end else if (op == OpAccess && ages[j] < cur_age) begin
                    ages_next[j] = ages[j] + 1'b1;
                end else if (op == OpInvalidate && ages[j] > cur_age) begin
                    ages_next[j] = ages[j] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lru_replacement_algorithm.sv
// True-LRU replacement engine for one cache set.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   accessEnable           : line lastAccessedCacheLine was hit or filled
//   invalidateEnable       : line invalidatedCacheLine was invalidated
//   replacementCacheLine   : current LRU line, decoded from registered ages only
module lru_replacement_algorithm
    import cache_replacement_pkg::*;
#(
    parameter int unsigned NUMBER_OF_CACHE_LINES = 4,
    parameter int unsigned COUNTER_WIDTH = counter_width(NUMBER_OF_CACHE_LINES)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     accessEnable,
    input  logic [COUNTER_WIDTH-1:0] lastAccessedCacheLine,
    input  logic                     invalidateEnable,
    input  logic [COUNTER_WIDTH-1:0] invalidatedCacheLine,
    output logic [COUNTER_WIDTH-1:0] replacementCacheLine
);

    localparam int unsigned N = NUMBER_OF_CACHE_LINES;
    localparam logic [COUNTER_WIDTH-1:0] LruAge = COUNTER_WIDTH'(lru_age(N));

    logic [N-1:0][COUNTER_WIDTH-1:0] ages_q;
    logic [N-1:0][COUNTER_WIDTH-1:0] ages_acc;
    logic [N-1:0][COUNTER_WIDTH-1:0] ages_d;
    logic                            access_effective;

    // Invalidate wins when both operations hit the same line.
    assign access_effective = accessEnable &&
        !(invalidateEnable && (lastAccessedCacheLine == invalidatedCacheLine));

    lru_age_update #(
        .NUMBER_OF_CACHE_LINES(N),
        .COUNTER_WIDTH        (COUNTER_WIDTH)
    ) u_access (
        .ages     (ages_q),
        .op       (OpAccess),
        .index    (lastAccessedCacheLine),
        .enable   (access_effective),
        .ages_next(ages_acc)
    );

    lru_age_update #(
        .NUMBER_OF_CACHE_LINES(N),
        .COUNTER_WIDTH        (COUNTER_WIDTH)
    ) u_invalidate (
        .ages     (ages_acc),
        .op       (OpInvalidate),
        .index    (invalidatedCacheLine),
        .enable   (invalidateEnable),
        .ages_next(ages_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                ages_q[i] <= COUNTER_WIDTH'(N - 1 - i);
            end
        end else begin
            ages_q <= ages_d;
        end
    end

    // Falls back to line 0 if no counter holds the LRU age.
    always_comb begin
        replacementCacheLine = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ages_q[i] == LruAge) begin
                replacementCacheLine = COUNTER_WIDTH'(i);
            end
        end
    end

    // Permutation check; armed once the first reset has been seen.
    logic [(2**COUNTER_WIDTH)-1:0] age_seen;
    logic                          perm_ok;
    logic                          init_q;

    always_comb begin
        age_seen = '0;
        for (int unsigned i = 0; i < N; i++) begin
            age_seen[ages_q[i]] = 1'b1;
        end
        perm_ok = &age_seen[N-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            init_q <= 1'b1;
        end
    end

    ages_permutation: assert property (@(posedge clock) disable iff (reset || !init_q) perm_ok);

endmodule
